// File: rtl/hls_fsm_pkg.sv
// Shared FSM definitions for HLS-style controllers.
//   state_t    : one-hot 3-bit state encoding (IDLE/RUN/DONE), matching the
//                one-hot style of the existing HLS-generated FSMs.
//   TIMEOUT_EN : 1 when GCD_TIMEOUT_EN is defined, else 0. When it is 0 the
//                step-bound logic folds away to constants.
package hls_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

`ifdef GCD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

endpackage

// File: rtl/gcd_step.sv
// One combinational subtract/swap Euclid step.
// Ports:
//   x, y    in  WIDTH  current operand pair
//   x_nxt   out WIDTH  x-y when x>=y, otherwise y (swap)
//   y_nxt   out WIDTH  y when x>=y, otherwise x (swap)
//   is_done out 1      y==0, the pair has converged and x holds the gcd
module gcd_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x_nxt,
    output logic [WIDTH-1:0] y_nxt,
    output logic             is_done
);

    // Compare before subtracting, so x-y never underflows.
    always_comb begin
        if (x >= y) begin
            x_nxt = x - y;
            y_nxt = y;
        end else begin
            x_nxt = y;
            y_nxt = x;
        end
    end

    assign is_done = (y == '0);

endmodule

// File: rtl/gcd_param_hs.sv
// Handshaked, parametrised GCD engine (subtract/swap Euclid, one step per clock).
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   in_valid/in_ready, a, b operand input handshake
//   out_valid/out_ready     result handshake; outputs are held until taken
//   result                  gcd(a,b), 0 on timeout
//   iter_cnt                subtract/swap steps performed, saturating
//   err                     run aborted by the step bound
// Optional feature: define GCD_TIMEOUT_EN to abort runs after MAX_ITER steps;
// without it err is constant 0 and run time is unbounded.
module gcd_param_hs
    import hls_fsm_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_ITER = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x, y, x_nxt, y_nxt;
    logic             is_done;
    logic             accept;
    logic             timeout;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .x       (x),
        .y       (y),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt),
        .is_done (is_done)
    );

    // Held low during reset so nothing is accepted while the block is cleared.
    // In DONE a new job is taken in the same cycle the result leaves.
    assign in_ready  = ~sys_rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    // Constant 0 when the step bound is compiled out.
    assign timeout   = TIMEOUT_EN & (iter_cnt == ITER_LIM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (is_done || timeout) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            result   <= '0;
            iter_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x        <= a;
                y        <= b;
                iter_cnt <= '0;
                err      <= 1'b0;
            end else if (state == RUN) begin
                if (is_done) begin
                    result <= x;
                end else if (timeout) begin
                    result <= '0;
                    err    <= 1'b1;
                end else begin
                    x <= x_nxt;
                    y <= y_nxt;
                    if (iter_cnt != CNT_MAX) iter_cnt <= iter_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_param_hs.sv
// Self-checking bench for gcd_param_hs (WIDTH=8, CNT_W=8 so the saturating
// counter is reachable). Expected values come from a division-based Euclid
// model: each quotient stage q contributes q subtractions plus one swap.
// Honours GCD_TIMEOUT_EN with MAX_ITER=20.
module tb_gcd_param_hs;

    localparam int WIDTH    = 8;
    localparam int CNT_W    = 8;
    localparam int MAX_ITER = 20;
`ifdef GCD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             in_valid, in_ready, out_valid, out_ready, err;
    logic [WIDTH-1:0] a, b, result;
    logic [CNT_W-1:0] iter_cnt;

    int checks   = 0;
    int failures = 0;

    gcd_param_hs #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .iter_cnt  (iter_cnt),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: gcd via modulo, steps via quotient sum, then bound/saturation.
    task automatic model(input int aa, input int bb, output int g, output int cnt,
                         output int e, output int lat);
        int u = aa, v = bb, s = 0, t;
        if (u < v) begin t = u; u = v; v = t; s++; end
        while (v != 0) begin
            s += u / v + 1;
            t = u % v;
            u = v;
            v = t;
        end
        if (TO_EN && s > MAX_ITER) begin
            g = 0; cnt = MAX_ITER; e = 1; lat = MAX_ITER + 1;
        end else begin
            g = u; cnt = (s > 2**CNT_W - 1) ? 2**CNT_W - 1 : s; e = 0; lat = s + 1;
        end
    endtask

    // Present operands until accepted; returns at the negedge after acceptance.
    task automatic start_job(input int aa, input int bb);
        int n = 0;
        a = WIDTH'(aa); b = WIDTH'(bb); in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge sys_clk); n++; end
        chk("accept_ready", in_ready, 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after acceptance; counts clocks to out_valid.
    task automatic wait_result(input int aa, input int bb);
        int g, cnt, e, lat, n = 0;
        model(aa, bb, g, cnt, e, lat);
        while (!out_valid && n < 600) begin @(negedge sys_clk); n++; end
        chk($sformatf("latency(%0d,%0d)", aa, bb), n, lat);
        chk($sformatf("result(%0d,%0d)", aa, bb), result, g);
        chk($sformatf("iter_cnt(%0d,%0d)", aa, bb), iter_cnt, cnt);
        chk($sformatf("err(%0d,%0d)", aa, bb), err, e);
    endtask

    // Hold off the consumer for 'stall' cycles, then take the result.
    task automatic take(input int stall);
        logic [WIDTH-1:0] r0 = result;
        logic [CNT_W-1:0] c0 = iter_cnt;
        for (int i = 0; i < stall; i++) begin
            @(negedge sys_clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, r0);
            chk("hold_cnt", iter_cnt, c0);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
        chk("released", out_valid, 0);
    endtask

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_iter_cnt", iter_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);
        @(negedge sys_clk);

        // Directed: reference case, degenerate inputs, saturation / timeout.
        start_job(48, 18);  wait_result(48, 18);  take(0);
        start_job(0, 0);    wait_result(0, 0);    take(1);
        start_job(7, 0);    wait_result(7, 0);    take(0);
        start_job(0, 5);    wait_result(0, 5);    take(0);
        start_job(255, 1);  wait_result(255, 1);  take(0);
        start_job(100, 1);  wait_result(100, 1);  take(0);

        // Backpressure, then back-to-back accept in the taking cycle.
        start_job(48, 18);  wait_result(48, 18);
        take_backtoback();

        // Reset mid-run discards the job.
        start_job(250, 3);
        repeat (9) @(negedge sys_clk);
        chk("midrun_busy", out_valid, 0);
        sys_rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_result", result, 0);
        chk("midrst_iter_cnt", iter_cnt, 0);
        chk("midrst_err", err, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        start_job(9, 6);    wait_result(9, 6);    take(0);

        // Randomized jobs with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            int ra = $urandom_range(0, 255);
            int rb = $urandom_range(0, 255);
            start_job(ra, rb);
            wait_result(ra, rb);
            take($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic take_backtoback();
        logic [WIDTH-1:0] r0 = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, r0);
            chk("bp_cnt", iter_cnt, 8);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        start_job(21, 14);
        out_ready = 1'b0;
        chk("b2b_no_stale_valid", out_valid, 0);
        wait_result(21, 14);
        take(0);
    endtask

endmodule
